pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the
//  enable_bar and synchronous-clear inputs of the PC, IF/ID and ID/EX pipeline
//  registers. Resolves load-use hazards, taken-branch squash and the multi-cycle
//  mult/div unit (MDU) busy interlock; keeps a stall-cycle performance counter.
// PARAMETERS
//  MDU_CYCLES  32  EX-occupancy of one mult/div op, cycles (legal 2..255)
//  CNT_W       32  width of stall_cycles performance counter
// PORTS
//  clk            in   1      clock, all state on posedge
//  rst            in   1      synchronous, active-high reset
//  id_rs          in   5      rs field of instruction in ID
//  id_rt          in   5      rt field of instruction in ID
//  id_uses_rs     in   1      ID instruction reads rs
//  id_uses_rt     in   1      ID instruction reads rt
//  id_mdu_op      in   1      ID instruction is mult/multu/div/divu
//  id_hilo_rd     in   1      ID instruction is mfhi/mflo
//  ex_mem_read    in   1      instruction in EX is a load
//  ex_rd_dst      in   5      destination register of instruction in EX
//  ex_branch_tkn  in   1      branch/jump in EX resolved taken
//  pc_en_bar      out  1      1 = hold PC
//  ifid_en_bar    out  1      1 = hold IF/ID register
//  ifid_flush     out  1      1 = clear IF/ID register (drives its rst)
//  idex_flush     out  1      1 = clear ID/EX register (inject bubble)
//  mdu_busy       out  1      MDU countdown nonzero
//  stall_cycles   out  CNT_W  count of cycles with pc_en_bar=1
// BEHAVIOUR
//  Hazard terms (combinational, from current inputs and state):
//   lu   = ex_mem_read & ex_rd_dst!=0 & ((id_uses_rs & id_rs==ex_rd_dst) |
//          (id_uses_rt & id_rt==ex_rd_dst))
//   mduh = mdu_busy & (id_mdu_op | id_hilo_rd)
//   stall = (lu | mduh) & ~ex_branch_tkn
//  Priority: ex_branch_tkn > stall > run.
//   taken: pc_en_bar=0, ifid_en_bar=0, ifid_flush=1, idex_flush=1.
//   stall: pc_en_bar=1, ifid_en_bar=1, ifid_flush=0, idex_flush=1.
//   run  : all four 0.
//  Register 0 never creates a load-use hazard.
//  MDU countdown (8-bit cnt): mdu_issue = id_mdu_op & ~stall & ~ex_branch_tkn.
//   On mdu_issue cnt <= MDU_CYCLES (op enters EX next cycle); else if cnt!=0
//   cnt <= cnt-1. mdu_busy = (cnt!=0), registered. A branch squash of the ID
//   instruction cancels issue; an op already counting is never cancelled.
//  State machine (registered, diagnostic and next-cycle gating):
//   RUN -> LSTALL on lu; RUN -> MWAIT on mduh; LSTALL -> RUN after 1 cycle
//   (bubble resolves lu); MWAIT -> RUN when cnt reaches 1 -> 0; any state ->
//   RUN on ex_branch_tkn. Outputs are derived from hazard terms, not state, so
//   a stall lasts exactly as long as its condition: load-use = 1 cycle;
//   MDU wait = remaining cnt cycles.
//  stall_cycles increments each cycle pc_en_bar=1; wraps at 2^CNT_W-1 -> 0.
//  Reset: cnt=0, state=RUN, stall_cycles=0, mdu_busy=0; during rst outputs
//   pc_en_bar=0, ifid_en_bar=0, ifid_flush=1, idex_flush=1 (clear pipe).
//   Reset mid-MDU-op abandons the count; no hazard is asserted after release.
//  Simultaneous lu & mduh: single stall; leaves when both clear.
//  Latency: all outputs combinational from same-cycle inputs plus registered
//   cnt; no extra cycle between hazard detection and pipeline hold.
// STRUCTURE
//  Shared package pipe_pkg: state encodings RUN/LSTALL/MWAIT, REG_ZERO=5'd0,
//   MDU_CNT_W=8. One sub-module: mdu_busy_counter (load/decrement/busy).
//  Pipeline registers remain separate M_S_FF instances in the top level.
// TESTING
//  1 lw $5 in EX, ID reads rs=5 -> exactly 1 cycle pc_en_bar=ifid_en_bar=
//    idex_flush=1; stall_cycles 0->1.
//  2 lw $0 in EX, ID reads rs=0 -> no stall, all outputs 0.
//  3 ex_branch_tkn=1 with lu true -> ifid_flush=idex_flush=1, pc_en_bar=0,
//    no stall counted.
//  4 mult issued, mflo in ID next cycle, MDU_CYCLES=4 -> mdu_busy 4 cycles,
//    stall 4 cycles, mflo proceeds in 5th cycle; stall_cycles=4.
//  5 mult issued, rst pulsed on cycle 2 -> mdu_busy=0 next cycle, flushes
//    asserted during rst, no stall afterwards.
//  6 Force stall_cycles=2^CNT_W-1 (CNT_W=4), one stall -> wraps to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings and helpers for the pipeline hazard sequencer.
package pipe_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_LSTALL = 2'd1;
  localparam logic [1:0] ST_MWAIT  = 2'd2;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         MDU_CNT_W = 8;

  typedef struct packed {
    logic pc_en_bar;
    logic ifid_en_bar;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctl_t;

  // Reset clears the pipe; otherwise taken branch outranks a stall.
  function automatic pipe_ctl_t pipe_ctl(input logic rst, input logic tkn, input logic stall);
    pipe_ctl_t c;
    if (rst || tkn)  c = '{pc_en_bar: 1'b0, ifid_en_bar: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
    else if (stall)  c = '{pc_en_bar: 1'b1, ifid_en_bar: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b1};
    else             c = '{pc_en_bar: 1'b0, ifid_en_bar: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// Mult/div occupancy countdown: loads on issue, decrements to zero, flags busy.
module mdu_busy_counter
  import pipe_pkg::*;
#(
  parameter int MDU_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  output logic [MDU_CNT_W-1:0] cnt,
  output logic                 busy
);

  localparam logic [MDU_CNT_W-1:0] LOAD_VAL = MDU_CNT_W'(MDU_CYCLES);

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= LOAD_VAL;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash,
// MDU busy interlock and a stall-cycle performance counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mdu_op,
  input  logic             id_hilo_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_dst,
  input  logic             ex_branch_tkn,
  output logic             pc_en_bar,
  output logic             ifid_en_bar,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic                 lu, mduh, stall, mdu_issue;
  logic [MDU_CNT_W-1:0] cnt;
  logic [1:0]           state, state_nxt;
  pipe_ctl_t            ctl;

  assign lu = ex_mem_read && (ex_rd_dst != REG_ZERO) &&
              ((id_uses_rs && (id_rs == ex_rd_dst)) ||
               (id_uses_rt && (id_rt == ex_rd_dst)));
  assign mduh      = mdu_busy && (id_mdu_op || id_hilo_rd);
  assign stall     = (lu || mduh) && !ex_branch_tkn;
  assign mdu_issue = id_mdu_op && !stall && !ex_branch_tkn;

  mdu_busy_counter #(.MDU_CYCLES(MDU_CYCLES)) u_mdu_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (mdu_issue),
    .cnt  (cnt),
    .busy (mdu_busy)
  );

  assign ctl         = pipe_ctl(rst, ex_branch_tkn, stall);
  assign pc_en_bar   = ctl.pc_en_bar;
  assign ifid_en_bar = ctl.ifid_en_bar;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;

  always_ff @(posedge clk) begin
    if (rst)            stall_cycles <= '0;
    else if (pc_en_bar) stall_cycles <= stall_cycles + 1'b1;
  end

  // Diagnostic view of which hazard is holding the pipe; outputs do not depend on it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (mduh) state_nxt = ST_MWAIT;
                 else if (lu) state_nxt = ST_LSTALL;
      ST_LSTALL: state_nxt = ST_RUN;
      ST_MWAIT:  if (cnt <= MDU_CNT_W'(1)) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
    if (ex_branch_tkn) state_nxt = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

endmodule
